// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate generator feeding a 2-entry in-order output FIFO.
// Optional feature macro: IMM_ZTYPE_CSR_EN (enables the Z-type CSR uimm on code 3'd6).
module imm_gen_stage #(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [2:0]           imm_type,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm_out,
    output logic                 type_err,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;
`ifdef IMM_ZTYPE_CSR_EN
    localparam logic [2:0] T_Z = 3'd6;
`endif

    logic [XLEN-1:0] mem_imm [2];
    logic            mem_err [2];
    logic            wptr, rptr, n_rptr;
    logic [1:0]      count, n_count;
    logic            push, pop, hit;
    logic [31:0]     v;
    logic            err;
    logic [XLEN-1:0] new_imm;
    logic            unused_low;

    assign unused_low = ^instr[6:0];
    assign in_ready   = count != 2'd2;
    assign out_valid  = count != 2'd0;
    assign push       = in_valid && in_ready && !flush;
    assign pop        = out_valid && out_ready;
    assign new_imm    = XLEN'($signed(v));

    // Form the 32-bit immediate; every class fits in 32 bits and is then sign-extended to XLEN
    always_comb begin
        v = (imm_type == T_I) ? {{20{instr[31]}}, instr[31:20]} :
            (imm_type == T_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            (imm_type == T_B) ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
            (imm_type == T_U) ? {instr[31:12], 12'd0} :
            (imm_type == T_J) ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
            32'd0;
        err = imm_type >= 3'd6;
`ifdef IMM_ZTYPE_CSR_EN
        if (imm_type == T_Z) begin
            v   = {27'd0, instr[19:15]};
            err = 1'b0;
        end
`endif
    end

    // Next head: a push lands directly on the head slot when it is the one being read next
    always_comb begin
        n_count = count + {1'b0, push} - {1'b0, pop};
        n_rptr  = rptr ^ pop;
        hit     = push && (n_rptr == wptr);
    end

    // Storage array; contents only matter while count covers them, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wptr] <= err ? '0 : new_imm;
            mem_err[wptr] <= err;
        end
    end

    // Occupancy, pointers and the registered head; head holds its value once the FIFO empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            imm_out  <= '0;
            type_err <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            count <= n_count;
            wptr  <= wptr ^ push;
            rptr  <= n_rptr;
            if (n_count != 2'd0) begin
                imm_out  <= hit ? (err ? '0 : new_imm) : mem_imm[n_rptr];
                type_err <= hit ? err : mem_err[n_rptr];
            end
        end
    end

    // Saturating count of accepted illegal-type instructions; survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count <= '0;
        else if (push && err && !(&err_count)) err_count <= err_count + 1'b1;
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: scoreboard bench for imm_gen_stage at XLEN=32 and XLEN=64.
module tb_imm_gen_stage;
    typedef struct {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = '0;
    logic [2:0]  imm_type = '0;
    logic        in_ready, out_valid, type_err;
    logic [31:0] imm_out;
    logic [7:0]  err_count;

    logic        w_in_valid = 1'b0;
    logic        w_out_ready = 1'b1;
    logic [31:0] w_instr = '0;
    logic [2:0]  w_type = '0;
    logic        w_in_ready, w_out_valid, w_type_err;
    logic [63:0] w_imm_out;
    logic [7:0]  w_err_count;

    exp_t q32[$];
    exp_t q64[$];
    exp_t m32, m64;
    int   checks = 0;
    int   failures = 0;
    int   exp_ec = 0;

    imm_gen_stage #(.XLEN(32), .ERR_CNT_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_type(imm_type), .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .type_err(type_err), .err_count(err_count)
    );

    imm_gen_stage #(.XLEN(64), .ERR_CNT_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .instr(w_instr), .imm_type(w_type), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .imm_out(w_imm_out), .type_err(w_type_err), .err_count(w_err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (q32.size() == 0) check("unexpected_out32", {63'd0, out_valid}, 64'd0);
            else begin
                m32 = q32.pop_front();
                check("imm32", {32'd0, imm_out}, m32.imm);
                check("err32", {63'd0, type_err}, {63'd0, m32.err});
            end
        end
        if (rst_n && w_out_valid && w_out_ready) begin
            if (q64.size() == 0) check("unexpected_out64", {63'd0, w_out_valid}, 64'd0);
            else begin
                m64 = q64.pop_front();
                check("imm64", w_imm_out, m64.imm);
                check("err64", {63'd0, w_type_err}, {63'd0, m64.err});
            end
        end
    end

    task automatic send(input logic [2:0] t, input logic [31:0] w, input logic [63:0] ei, input logic e);
        int n = 0;
        imm_type = t;
        instr    = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            q32.push_back('{ei, e});
            if (e && exp_ec < 255) exp_ec++;
        end else check("accept_timeout32", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send64(input logic [2:0] t, input logic [31:0] w, input logic [63:0] ei);
        int n = 0;
        w_type     = t;
        w_instr    = w;
        w_in_valid = 1'b1;
        while (!w_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (w_in_ready) q64.push_back('{ei, 1'b0});
        else check("accept_timeout64", {63'd0, w_in_ready}, 64'd1);
        @(negedge clk);
        w_in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int ec0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_imm_out", {32'd0, imm_out}, 64'd0);
        check("rst_type_err", {63'd0, type_err}, 64'd0);
        check("rst_err_count", {56'd0, err_count}, 64'd0);
        check("rst_imm_out64", w_imm_out, 64'd0);
        check("rst_out_valid64", {63'd0, w_out_valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

        send(3'd1, 32'hFFF00093, 64'hFFFFFFFF, 1'b0);
        check("latency_out_valid", {63'd0, out_valid}, 64'd1);
        send(3'd3, 32'hFE000EE3, 64'hFFFFFFFC, 1'b0);
        send(3'd5, 32'hFF9FF06F, 64'hFFFFFFF8, 1'b0);
        send(3'd2, 32'hFE112E23, 64'hFFFFFFFC, 1'b0);
        send(3'd4, 32'h123450B7, 64'h12345000, 1'b0);
        send(3'd0, 32'hFFFFFFB3, 64'h0, 1'b0);
        send(3'd7, 32'hFFF00093, 64'h0, 1'b1);
`ifdef IMM_ZTYPE_CSR_EN
        send(3'd6, 32'h340FD073, 64'h1F, 1'b0);
`else
        send(3'd6, 32'h340FD073, 64'h0, 1'b1);
`endif
        @(negedge clk);
        check("err_count_after_types", {56'd0, err_count}, 64'(exp_ec));

        send64(3'd4, 32'h123450B7, 64'h0000000012345000);
        send64(3'd4, 32'h800000B7, 64'hFFFFFFFF80000000);
        send64(3'd1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF);

        out_ready = 1'b0;
        send(3'd1, 32'h00100093, 64'd1, 1'b0);
        send(3'd1, 32'h00200093, 64'd2, 1'b0);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        fork
            send(3'd1, 32'h00300093, 64'd3, 1'b0);
        join_none
        repeat (3) @(negedge clk);
        check("held_in_ready", {63'd0, in_ready}, 64'd0);
        check("held_head", {32'd0, imm_out}, 64'd1);
        out_ready = 1'b1;
        wait fork;
        repeat (3) @(negedge clk);

        out_ready = 1'b0;
        send(3'd1, 32'h00100093, 64'd1, 1'b0);
        send(3'd1, 32'h00200093, 64'd2, 1'b0);
        ec0 = exp_ec;
        flush    = 1'b1;
        in_valid = 1'b1;
        imm_type = 3'd7;
        instr    = 32'h00500093;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_err_count", {56'd0, err_count}, 64'(ec0));
        q32.delete();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("flush_word_lost", {63'd0, out_valid}, 64'd0);

        for (int i = 0; i < 300; i++) send(3'd7, 32'(i), 64'h0, 1'b1);
        @(negedge clk);
        check("err_count_saturated", {56'd0, err_count}, 64'hFF);

        out_ready = 1'b0;
        send(3'd1, 32'h00100093, 64'd1, 1'b0);
        send(3'd7, 32'h00200093, 64'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_err_count", {56'd0, err_count}, 64'd0);
        q32.delete();
        exp_ec = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_no_emit", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);

        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain64", 64'(q64.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
